// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM arbiter.
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identity (core or debug)
//   ADDR_W/DATA_W : SRAM word address and data widths
//   CNT_W       : access timer width, wide enough for ACCESS_CYCLES up to 15
package sram_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

endpackage

// File: rtl/sram_access_timer.sv
// Loadable down-counter that times how long the SRAM enable is held.
//   i_clk, i_reset : clock and synchronous active-high reset
//   i_load         : load i_loadVal (takes priority over decrement)
//   i_loadVal      : value to load
//   i_dec          : decrement by one, saturating at zero
//   o_zero         : count is zero
import sram_arb_pkg::*;

module sram_access_timer (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a single-port SRAM between the processor core and the debug
// (JTAG) port. One access at a time; ties are resolved round-robin, and
// i_dbgLock keeps the core off the bus while debug owns it.
//
// Ports:
//   i_clk, i_reset                    clock, synchronous active-high reset
//   i_coreReq/Wr/Addr/Data, o_coreAck core requester
//   i_dbgReq/Wr/Addr/Data,  o_dbgAck  debug requester
//   i_dbgLock                         blocks new core grants
//   o_rdData                          read data, shared, held until next read
//   o_sramAddr/Data/Drive/Wr/En       SRAM bus, i_sramData read return
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for an eligible request; latches the winner
// ST_ACCESS | SRAM enabled for ACCESS_CYCLES cycles; read captured last
// ST_ACK    | one-cycle ack to the winner, last-served pointer updated
import sram_arb_pkg::*;

module sram_arbiter #(
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_coreReq,
    input  logic              i_coreWr,
    input  logic [ADDR_W-1:0] i_coreAddr,
    input  logic [DATA_W-1:0] i_coreData,
    output logic              o_coreAck,
    input  logic              i_dbgReq,
    input  logic              i_dbgWr,
    input  logic [ADDR_W-1:0] i_dbgAddr,
    input  logic [DATA_W-1:0] i_dbgData,
    output logic              o_dbgAck,
    input  logic              i_dbgLock,
    output logic [DATA_W-1:0] o_rdData,
    output logic [ADDR_W-1:0] o_sramAddr,
    output logic [DATA_W-1:0] o_sramData,
    output logic              o_sramDrive,
    input  logic [DATA_W-1:0] i_sramData,
    output logic              o_sramWr,
    output logic              o_sramEn
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    req_id_t           r_winner;
    req_id_t           r_lastServed;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdData;

    logic w_coreElig;
    logic w_dbgElig;
    logic w_grantDbg;
    logic w_load;
    logic w_dec;
    logic w_zero;
    logic w_capture;

    sram_access_timer u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_load),
        .i_loadVal (LOAD_VAL),
        .i_dec     (w_dec),
        .o_zero    (w_zero)
    );

    always_comb begin
        w_coreElig = i_coreReq && !i_dbgLock;
        w_dbgElig  = i_dbgReq;
        // On a tie the requester not served last wins; otherwise whoever asks.
        if (w_coreElig && w_dbgElig) begin
            w_grantDbg = (r_lastServed == REQ_CORE);
        end else begin
            w_grantDbg = w_dbgElig;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_capture   = 1'b0;
        o_sramEn    = 1'b0;
        o_sramWr    = 1'b0;
        o_sramDrive = 1'b0;
        o_coreAck   = 1'b0;
        o_dbgAck    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_coreElig || w_dbgElig) begin
                    w_load      = 1'b1;
                    w_nextState = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_sramEn    = 1'b1;
                o_sramWr    = r_wr;
                o_sramDrive = r_wr;
                if (w_zero) begin
                    w_capture   = !r_wr;
                    w_nextState = ST_ACK;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ACK: begin
                o_coreAck   = (r_winner == REQ_CORE);
                o_dbgAck    = (r_winner == REQ_DBG);
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_winner     <= REQ_CORE;
            r_lastServed <= REQ_DBG;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_rdData     <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_load) begin
                r_winner <= w_grantDbg ? REQ_DBG   : REQ_CORE;
                r_wr     <= w_grantDbg ? i_dbgWr   : i_coreWr;
                r_addr   <= w_grantDbg ? i_dbgAddr : i_coreAddr;
                r_data   <= w_grantDbg ? i_dbgData : i_coreData;
            end
            if (w_capture) begin
                r_rdData <= i_sramData;
            end
            if (r_state == ST_ACK) begin
                r_lastServed <= r_winner;
            end
        end
    end

    // The latched fields double as the SRAM bus so they hold between accesses.
    assign o_sramAddr = r_addr;
    assign o_sramData = r_data;
    assign o_rdData   = r_rdData;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        coreReq, coreWr, dbgReq, dbgWr, dbgLock;
    logic [15:0] coreAddr, coreData, dbgAddr, dbgData, sramIn;

    logic        coreAck1, dbgAck1, sramDrive1, sramWr1, sramEn1;
    logic [15:0] rdData1, sramAddr1, sramData1;
    logic        coreAck3, dbgAck3, sramDrive3, sramWr3, sramEn3;
    logic [15:0] rdData3, sramAddr3, sramData3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst),
        .i_coreReq(coreReq), .i_coreWr(coreWr), .i_coreAddr(coreAddr),
        .i_coreData(coreData), .o_coreAck(coreAck1),
        .i_dbgReq(dbgReq), .i_dbgWr(dbgWr), .i_dbgAddr(dbgAddr),
        .i_dbgData(dbgData), .o_dbgAck(dbgAck1), .i_dbgLock(dbgLock),
        .o_rdData(rdData1), .o_sramAddr(sramAddr1), .o_sramData(sramData1),
        .o_sramDrive(sramDrive1), .i_sramData(sramIn), .o_sramWr(sramWr1),
        .o_sramEn(sramEn1)
    );

    sram_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_reset(rst),
        .i_coreReq(coreReq), .i_coreWr(coreWr), .i_coreAddr(coreAddr),
        .i_coreData(coreData), .o_coreAck(coreAck3),
        .i_dbgReq(dbgReq), .i_dbgWr(dbgWr), .i_dbgAddr(dbgAddr),
        .i_dbgData(dbgData), .o_dbgAck(dbgAck3), .i_dbgLock(dbgLock),
        .o_rdData(rdData3), .o_sramAddr(sramAddr3), .o_sramData(sramData3),
        .o_sramDrive(sramDrive3), .i_sramData(sramIn), .o_sramWr(sramWr3),
        .o_sramEn(sramEn3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        coreReq = 0; coreWr = 0; coreAddr = 0; coreData = 0;
        dbgReq = 0; dbgWr = 0; dbgAddr = 0; dbgData = 0;
        dbgLock = 0; sramIn = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (sramEn1 !== 1'b0 || sramEn3 !== 1'b0) begin
            $display("FAIL reset_en: got %b/%b want 0/0", sramEn1, sramEn3); n_fail++; end
        n_checks++; if ({sramWr1, sramDrive1, sramWr3, sramDrive3} !== 4'b0) begin
            $display("FAIL reset_wr_drive: got %b want 0000", {sramWr1, sramDrive1, sramWr3, sramDrive3}); n_fail++; end
        n_checks++; if ({coreAck1, dbgAck1, coreAck3, dbgAck3} !== 4'b0) begin
            $display("FAIL reset_acks: got %b want 0000", {coreAck1, dbgAck1, coreAck3, dbgAck3}); n_fail++; end
        n_checks++; if (sramAddr1 !== 16'h0 || sramData1 !== 16'h0 || rdData1 !== 16'h0) begin
            $display("FAIL reset_buses: got %h %h %h want 0 0 0", sramAddr1, sramData1, rdData1); n_fail++; end
        n_checks++; if (sramAddr3 !== 16'h0 || sramData3 !== 16'h0 || rdData3 !== 16'h0) begin
            $display("FAIL reset_buses3: got %h %h %h want 0 0 0", sramAddr3, sramData3, rdData3); n_fail++; end
    endtask

    task automatic test_core_read();
        apply_reset();
        coreReq = 1; coreWr = 0; coreAddr = 16'h0010; sramIn = 16'hBEEF;
        tick();
        n_checks++; if (sramEn1 !== 1'b1 || sramAddr1 !== 16'h0010 || sramWr1 !== 1'b0 || coreAck1 !== 1'b0) begin
            $display("FAIL core_read_c1: en=%b addr=%h wr=%b ack=%b want 1 0010 0 0", sramEn1, sramAddr1, sramWr1, coreAck1); n_fail++; end
        tick();
        n_checks++; if (coreAck1 !== 1'b1 || dbgAck1 !== 1'b0 || sramEn1 !== 1'b0) begin
            $display("FAIL core_read_ack: coreAck=%b dbgAck=%b en=%b want 1 0 0", coreAck1, dbgAck1, sramEn1); n_fail++; end
        n_checks++; if (rdData1 !== 16'hBEEF) begin
            $display("FAIL core_read_data: got %h want beef", rdData1); n_fail++; end
        coreReq = 0; sramIn = 16'h0000;
        tick();
        n_checks++; if (coreAck1 !== 1'b0 || sramEn1 !== 1'b0 || rdData1 !== 16'hBEEF || sramAddr1 !== 16'h0010) begin
            $display("FAIL core_read_idle: ack=%b en=%b rd=%h addr=%h want 0 0 beef 0010", coreAck1, sramEn1, rdData1, sramAddr1); n_fail++; end
    endtask

    task automatic test_round_robin();
        logic expCore, expDbg;
        apply_reset();
        coreReq = 1; coreAddr = 16'h0100; dbgReq = 1; dbgAddr = 16'h0200;
        for (int t = 1; t <= 9; t++) begin
            tick();
            expCore = (t == 2) || (t == 8);
            expDbg  = (t == 5);
            n_checks++; if (coreAck1 !== expCore || dbgAck1 !== expDbg) begin
                $display("FAIL rr_acks t=%0d: core=%b dbg=%b want %b %b", t, coreAck1, dbgAck1, expCore, expDbg); n_fail++; end
            if (t == 4) begin
                n_checks++; if (sramAddr1 !== 16'h0200 || sramEn1 !== 1'b1) begin
                    $display("FAIL rr_dbg_addr: addr=%h en=%b want 0200 1", sramAddr1, sramEn1); n_fail++; end
            end
        end
        coreReq = 0; dbgReq = 0;
    endtask

    task automatic test_back_to_back();
        logic expAck;
        apply_reset();
        coreReq = 1; coreAddr = 16'h0033;
        for (int t = 1; t <= 6; t++) begin
            tick();
            expAck = (t == 2) || (t == 5);
            n_checks++; if (coreAck1 !== expAck || sramEn1 !== ((t % 3) == 1)) begin
                $display("FAIL b2b t=%0d: ack=%b en=%b want %b %b", t, coreAck1, sramEn1, expAck, ((t % 3) == 1)); n_fail++; end
        end
        coreReq = 0;
    endtask

    task automatic test_lock();
        apply_reset();
        dbgLock = 1; coreReq = 1; coreAddr = 16'h0044;
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_checks++; if (sramEn1 !== 1'b0 || coreAck1 !== 1'b0) begin
                $display("FAIL lock_blocked t=%0d: en=%b ack=%b want 0 0", t, sramEn1, coreAck1); n_fail++; end
        end
        dbgLock = 0;
        tick();
        n_checks++; if (sramEn1 !== 1'b1 || coreAck1 !== 1'b0) begin
            $display("FAIL lock_release_c1: en=%b ack=%b want 1 0", sramEn1, coreAck1); n_fail++; end
        tick();
        n_checks++; if (coreAck1 !== 1'b1) begin
            $display("FAIL lock_release_ack: got %b want 1", coreAck1); n_fail++; end
        coreReq = 0;
    endtask

    task automatic test_dbg_write();
        apply_reset();
        dbgReq = 1; dbgWr = 1; dbgAddr = 16'h00FF; dbgData = 16'h1234;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_checks++; if ({sramEn3, sramWr3, sramDrive3} !== 3'b111 || sramAddr3 !== 16'h00FF ||
                            sramData3 !== 16'h1234 || dbgAck3 !== 1'b0) begin
                $display("FAIL dbg_write t=%0d: en/wr/drv=%b addr=%h data=%h ack=%b want 111 00ff 1234 0",
                         t, {sramEn3, sramWr3, sramDrive3}, sramAddr3, sramData3, dbgAck3); n_fail++; end
        end
        tick();
        n_checks++; if (dbgAck3 !== 1'b1 || coreAck3 !== 1'b0 || {sramEn3, sramWr3, sramDrive3} !== 3'b000) begin
            $display("FAIL dbg_write_ack: dbgAck=%b coreAck=%b en/wr/drv=%b want 1 0 000",
                     dbgAck3, coreAck3, {sramEn3, sramWr3, sramDrive3}); n_fail++; end
        n_checks++; if (sramAddr3 !== 16'h00FF || sramData3 !== 16'h1234 || rdData3 !== 16'h0000) begin
            $display("FAIL dbg_write_hold: addr=%h data=%h rd=%h want 00ff 1234 0000", sramAddr3, sramData3, rdData3); n_fail++; end
        dbgReq = 0; dbgWr = 0;
    endtask

    task automatic test_drop_and_lock_mid_access();
        apply_reset();
        coreReq = 1; coreWr = 1; coreAddr = 16'h0042; coreData = 16'h5555;
        tick();
        n_checks++; if (sramEn3 !== 1'b1) begin
            $display("FAIL drop_c1_en: got %b want 1", sramEn3); n_fail++; end
        coreReq = 0; coreAddr = 16'h9999; coreData = 16'h0000; dbgLock = 1;
        tick();
        n_checks++; if (sramAddr3 !== 16'h0042 || sramData3 !== 16'h5555 || sramEn3 !== 1'b1) begin
            $display("FAIL drop_latched: addr=%h data=%h en=%b want 0042 5555 1", sramAddr3, sramData3, sramEn3); n_fail++; end
        tick();
        n_checks++; if (sramEn3 !== 1'b1 || coreAck3 !== 1'b0) begin
            $display("FAIL drop_c3: en=%b ack=%b want 1 0", sramEn3, coreAck3); n_fail++; end
        tick();
        n_checks++; if (coreAck3 !== 1'b1 || sramAddr3 !== 16'h0042 || rdData3 !== 16'h0000) begin
            $display("FAIL drop_ack: ack=%b addr=%h rd=%h want 1 0042 0000", coreAck3, sramAddr3, rdData3); n_fail++; end
        tick();
        n_checks++; if (coreAck3 !== 1'b0 || sramEn3 !== 1'b0) begin
            $display("FAIL drop_after: ack=%b en=%b want 0 0", coreAck3, sramEn3); n_fail++; end
        dbgLock = 0; coreWr = 0;
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        coreReq = 1; coreWr = 0; coreAddr = 16'h0020; sramIn = 16'hA5A5;
        tick(); tick(); tick(); tick();
        n_checks++; if (coreAck3 !== 1'b1 || rdData3 !== 16'hA5A5) begin
            $display("FAIL rst_pre_read: ack=%b rd=%h want 1 a5a5", coreAck3, rdData3); n_fail++; end
        coreReq = 0;
        tick();
        coreReq = 1; coreAddr = 16'h0021; sramIn = 16'h1111;
        tick();
        tick();
        n_checks++; if (sramEn3 !== 1'b1 || sramAddr3 !== 16'h0021) begin
            $display("FAIL rst_in_access: en=%b addr=%h want 1 0021", sramEn3, sramAddr3); n_fail++; end
        rst = 1;
        tick();
        n_checks++; if (sramEn3 !== 1'b0 || coreAck3 !== 1'b0 || dbgAck3 !== 1'b0 || rdData3 !== 16'h0000 || sramAddr3 !== 16'h0000) begin
            $display("FAIL rst_abort: en=%b acks=%b%b rd=%h addr=%h want 0 00 0000 0000",
                     sramEn3, coreAck3, dbgAck3, rdData3, sramAddr3); n_fail++; end
        rst = 0; coreReq = 0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            n_checks++; if (sramEn3 !== 1'b0 || coreAck3 !== 1'b0) begin
                $display("FAIL rst_idle t=%0d: en=%b ack=%b want 0 0", t, sramEn3, coreAck3); n_fail++; end
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_round_robin();
        test_back_to_back();
        test_lock();
        test_dbg_write();
        test_drop_and_lock_mid_access();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of i_clk.
REQ-002 Parameter ACCESS_CYCLES, default 1: number of cycles o_sramEn is held per access (legal range 1..15).
REQ-003 Ports SHALL be exactly as follows:
- i_clk  in  1  system clock (uproc clock domain)
- i_reset  in  1  synchronous active-high reset
- i_coreReq  in  1  core access request, held until o_coreAck
- i_coreWr  in  1  core write (1) / read (0)
- i_coreAddr  in  16  core word address
- i_coreData  in  16  core write data
- o_coreAck  out  1  one-cycle completion pulse to core
- i_dbgReq  in  1  debug (JTAG) access request, held until o_dbgAck
- i_dbgWr  in  1  debug write (1) / read (0)
- i_dbgAddr  in  16  debug word address
- i_dbgData  in  16  debug write data
- o_dbgAck  out  1  one-cycle completion pulse to debug
- i_dbgLock  in  1  when high, core requests SHALL NOT be granted
- o_rdData  out  16  read data, valid in the ack cycle, shared by both requesters
- o_sramAddr  out  16  SRAM address
- o_sramData  out  16  SRAM write data
- o_sramDrive  out  1  tri-state enable for the SRAM data bus
- i_sramData  in  16  SRAM read data
- o_sramWr  out  1  SRAM write (active-high; inverted at chip level)
- o_sramEn  out  1  SRAM enable (active-high; inverted at chip level)

Function
REQ-004 FSM states: IDLE, ACCESS, ACK.
REQ-005 IDLE: when an eligible request exists, SHALL latch winner ID, wr, addr, and data, load the counter with ACCESS_CYCLES-1, and go to ACCESS; otherwise stay in IDLE.
REQ-006 Eligible: i_dbgReq; or i_coreReq && !i_dbgLock.
REQ-007 Both eligible: the requester not served last SHALL win (round-robin); a single eligible requester SHALL always win.
REQ-008 ACCESS: o_sramEn=1, o_sramAddr=latched addr, o_sramWr=latched wr, o_sramDrive=latched wr, o_sramData=latched data; counter decrements each cycle; at count 0, a read SHALL capture i_sramData into o_rdData, then go to ACK.
REQ-009 ACK: exactly one of o_coreAck/o_dbgAck=1 (the winner's); o_sramEn=0; last-served pointer updated; next state IDLE.
REQ-010 Latency: request seen in IDLE at cycle 0; o_sramEn high cycles 1..ACCESS_CYCLES; ack in cycle ACCESS_CYCLES+1; back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
REQ-011 A request still high in the ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-012 Request dropped mid-access: the access SHALL complete and the ack SHALL still be issued; latched fields SHALL NOT change during ACCESS/ACK.
REQ-013 i_dbgLock asserted mid-core-access: the current access SHALL complete normally; the lock only gates new grants.
REQ-014 o_rdData SHALL hold its value until the next read capture; after a write ack its value is unchanged.
REQ-015 Outside ACCESS: o_sramEn, o_sramWr, and o_sramDrive SHALL be 0; o_sramAddr and o_sramData SHALL hold their last values.

Reset
REQ-016 On i_reset: state=IDLE, all acks=0, o_sramEn/o_sramWr/o_sramDrive=0, o_sramAddr=0, o_sramData=0, o_rdData=0, counter=0, last-served=debug (so core wins the first tie).
REQ-017 Reset mid-access SHALL abort at the next edge with no ack issued.

Structure
REQ-018 Package sram_arb_pkg SHALL hold: state enum, requester-ID enum (REQ_CORE, REQ_DBG), ADDR_W=16, DATA_W=16.
REQ-019 One sub-module, sram_access_timer (loadable down-counter with zero flag), SHALL be used; round-robin selection SHALL remain inline.

Verification
REQ-020 Core read of 0x0010 with SRAM returning 0xBEEF, ACCESS_CYCLES=1 -> o_sramEn high for 1 cycle, o_coreAck at cycle 2, o_rdData=0xBEEF.
REQ-021 Simultaneous core and debug requests after reset, both held -> core served first, then debug; acks alternate core/dbg/core.
REQ-022 i_dbgLock=1 with only core requesting for 20 cycles -> no o_sramEn, no ack; lock drops -> core ack 2 cycles later.
REQ-023 Debug write 0x1234 to 0x00FF, ACCESS_CYCLES=3 -> o_sramWr, o_sramDrive, and o_sramEn high for exactly 3 cycles with addr 0x00FF and data 0x1234; o_dbgAck in cycle 4.
REQ-024 i_reset pulsed in the 2nd ACCESS cycle (ACCESS_CYCLES=3) -> next cycle o_sramEn=0, no ack, state IDLE, o_rdData=0.
